wb_writer: RTL
==============

# wb_writer

Writeback arbiter and register-file write-port driver for the RISC-V core. It accepts results from the ALU and the load/store unit over valid/ready handshakes and arbitrates between them, with ALU priority and an LSU starvation guard. It registers the winning result into a single-entry output stage that drives the register file's A3/WD3/WE3 write port, and keeps a 32-bit pending-write scoreboard that the issue stage uses for hazard checks.

## Interface
- STARVE_MAX, 3: consecutive cycles LSU may be refused while valid before it is forced to win (1..15)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU result available
- alu_ready  out  1  ALU result accepted this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- lsu_valid  in  1  LSU result available
- lsu_ready  out  1  LSU result accepted this cycle
- lsu_rd  in  5  LSU destination register
- lsu_data  in  32  LSU result
- iss_valid  in  1  instruction issued with a register destination
- iss_rd  in  5  destination of the issued instruction
- busy  out  32  scoreboard; bit n=1 means write to xn pending
- A3  out  5  register-file write address
- WD3  out  32  register-file write data
- WE3  out  1  register-file write enable
- rs1, rs2  in  5  read addresses of the consuming stage (forwarding)
- fwd1_hit, fwd2_hit  out  1  forwarding valid for rs1/rs2
- fwd1_data, fwd2_data  out  32  forwarded value

## Operation
- Arbitration is combinational in the current cycle. A handshake occurs when valid && ready; at most one handshake per cycle.
  - Default: ALU wins. alu_ready = alu_valid && !force_lsu; lsu_ready = lsu_valid && (!alu_valid || force_lsu).
  - force_lsu = (starve_cnt == STARVE_MAX).
- starve_cnt (4 bit), updated each cycle:
  - Increments when lsu_valid && !lsu_ready.
  - Clears when an LSU handshake occurs or lsu_valid=0.
  - Saturates at STARVE_MAX.
- Output stage: on a handshake, the winner's rd/data are loaded into A3/WD3 and wb_vld is set. With no handshake, wb_vld clears and A3/WD3 hold their values.
- WE3 = wb_vld && (A3 != 0). A result to x0 is accepted and consumes a slot but never writes.
- Scoreboard, per bit n≥1, at each edge:
  - Set if iss_valid && iss_rd==n.
  - Otherwise cleared if WE3 && A3==n.
  - Set wins on a same-cycle set/clear of the same bit.
  - busy[0] is constantly 0; iss_rd=0 is ignored.
- The block does not check producer data against busy; the issue stage owns stalls.

## Timing
- Reset values: alu_ready=0, lsu_ready=0, A3=0, WD3=0, WE3=0, busy=0, starve_cnt=0, all fwd outputs 0.
- Latency: handshake in cycle N → WE3 high during cycle N+1 → register file updated at the end-of-N+1 edge.
- Throughput: one result per cycle, no bubbles. Back-to-back writes to the same rd both occur, in order.
- Ready depends only on current valids and starve_cnt; there is no path from ready to valid.
- Asserting rst mid-operation immediately drops any pending output-stage write (WE3 falls asynchronously), clears busy, and clears starve_cnt.
- Producers must hold valid, rd, and data stable until their handshake.

## Configuration
- WB_FWD_EN defined: forwarding is enabled.
  - fwdN_hit = WE3 && (A3 == rsN), combinational.
  - fwdN_data = WD3 when hit, else 0.
  - This covers the write-cycle window in which the register file still returns the old value.
- WB_FWD_EN undefined: fwd1_hit, fwd2_hit, fwd1_data, and fwd2_data are tied to 0 and no compare logic is built. Ports remain present.

## Test plan
- After rst: all outputs 0. Then ALU handshake rd=5, data=0xDEADBEEF → next cycle WE3=1, A3=5, WD3=0xDEADBEEF; the cycle after, WE3=0.
- iss_valid with iss_rd=7 → busy[7]=1. LSU write rd=7 commits → busy[7]=0. Same-cycle iss_rd=7 with WE3 at A3=7 → busy[7] stays 1.
- alu_valid and lsu_valid held high continuously, STARVE_MAX=3 → ALU wins 3 cycles, LSU wins the 4th, and the pattern repeats (3:1).
- ALU write to rd=0 with data 0x1234 → alu_ready=1, next cycle WE3=0, busy unchanged. iss_rd=0 → busy[0] stays 0.
- rst pulsed in the cycle WE3=1 for rd=9 → WE3 drops immediately, busy=0, and no write occurs.
- WB_FWD_EN defined: WE3=1, A3=3, WD3=0xA5A5A5A5, rs1=3, rs2=4 → fwd1_hit=1 with fwd1_data=0xA5A5A5A5, fwd2_hit=0. Without the macro, both hits are 0.

Source files
------------

// File: rtl/wb_writer.sv
// -----------------------------------------------------------------------------
// wb_writer
//
// Writeback arbiter and register-file write-port driver.
//
// The ALU and the load/store unit each offer one result at a time over a
// valid/ready handshake. The ALU normally wins. If the LSU is refused for
// STARVE_MAX consecutive cycles, it wins the next cycle instead. The winning
// result is registered into a single-entry output stage, which drives the
// register-file write port (A3/WD3/WE3) during the following cycle. A 32-bit
// pending-write scoreboard (busy) is kept for the issue stage's hazard checks.
//
// Compile-time option:
//   WB_FWD_EN  When defined, builds a write-cycle forwarding path for two read
//              ports (rs1/rs2). When undefined, the fwd* outputs are tied to 0
//              and no compare logic is built.
//
// Parameters:
//   STARVE_MAX  Consecutive cycles the LSU may be refused while valid before it
//               is forced to win (1..15).
//
// Ports:
//   clk                    clock; all state updates on the rising edge
//   rst                    asynchronous, active-high reset
//   alu_valid/alu_ready    ALU result handshake
//   alu_rd, alu_data       ALU destination register and result
//   lsu_valid/lsu_ready    LSU result handshake
//   lsu_rd, lsu_data       LSU destination register and result
//   iss_valid, iss_rd      issued instruction with a register destination
//   busy[31:0]             scoreboard; bit n=1 means a write to xn is pending
//   A3, WD3, WE3           register-file write port
//   rs1, rs2               consumer read addresses (forwarding compare)
//   fwd1_hit, fwd2_hit     forwarding valid for rs1 / rs2
//   fwd1_data, fwd2_data   forwarded value (0 when there is no hit)
// -----------------------------------------------------------------------------
module wb_writer #(
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,

    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,

    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,

    output logic [31:0] busy,

    output logic [4:0]  A3,
    output logic [31:0] WD3,
    output logic        WE3,

    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        fwd1_hit,
    output logic        fwd2_hit,
    output logic [31:0] fwd1_data,
    output logic [31:0] fwd2_data
);

    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

    typedef enum logic {
        WB_IDLE = 1'b0,   // nothing to write this cycle
        WB_PEND = 1'b1    // output stage holds a result being written
    } wb_state_t;

    // -------------------------------------------------------------------------
    // Arbitration (combinational, current cycle)
    // -------------------------------------------------------------------------
    logic [3:0]  starve_cnt_reg;
    logic [3:0]  starve_cnt_next;
    logic        force_lsu;
    logic        alu_hs;
    logic        lsu_hs;
    logic [4:0]  win_rd;
    logic [31:0] win_data;

    assign force_lsu = (starve_cnt_reg == STARVE_LIMIT);

    // Readies are also held low while rst is asserted. That keeps them at 0
    // for the whole reset window, even if a producer asserts valid early.
    assign alu_ready = !rst && alu_valid && !force_lsu;
    assign lsu_ready = !rst && lsu_valid && (!alu_valid || force_lsu);

    assign alu_hs = alu_valid && alu_ready;
    assign lsu_hs = lsu_valid && lsu_ready;

    // The two readies are mutually exclusive, so a simple priority mux is
    // enough to select the winner.
    always_comb begin
        win_rd   = lsu_rd;
        win_data = lsu_data;
        if (alu_hs) begin
            win_rd   = alu_rd;
            win_data = alu_data;
        end
    end

    // Starvation counter: counts consecutive refused-while-valid LSU cycles
    // and saturates at the limit. It clears as soon as the LSU either wins or
    // withdraws.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!lsu_valid || lsu_hs) begin
            starve_cnt_next = 4'd0;
        end else if (starve_cnt_reg != STARVE_LIMIT) begin
            starve_cnt_next = starve_cnt_reg + 4'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Single-entry output stage
    // -------------------------------------------------------------------------
    wb_state_t   wb_state_reg;
    logic [4:0]  a3_reg;
    logic [31:0] wd3_reg;
    logic        we3_int;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_state_reg   <= WB_IDLE;
            a3_reg         <= 5'd0;
            wd3_reg        <= 32'd0;
            starve_cnt_reg <= 4'd0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            if (alu_hs || lsu_hs) begin
                wb_state_reg <= WB_PEND;
                a3_reg       <= win_rd;
                wd3_reg      <= win_data;
            end else begin
                // Address and data hold their values. Only the write is dropped.
                wb_state_reg <= WB_IDLE;
            end
        end
    end

    // Results aimed at x0 take a slot in the output stage but never write.
    // WE3 is derived from the registered state. Because that state is cleared
    // asynchronously, WE3 falls as soon as rst rises.
    assign we3_int = (wb_state_reg == WB_PEND) && (a3_reg != 5'd0);

    assign A3  = a3_reg;
    assign WD3 = wd3_reg;
    assign WE3 = we3_int;

    // -------------------------------------------------------------------------
    // Pending-write scoreboard
    // -------------------------------------------------------------------------
    // x0 is never pending.
    assign busy[0] = 1'b0;

    for (genvar gi = 1; gi < 32; gi++) begin : g_sb
        logic set_bit;
        logic clr_bit;
        logic busy_bit_reg;

        assign set_bit = iss_valid && (iss_rd == 5'(gi));
        assign clr_bit = we3_int && (a3_reg == 5'(gi));

        // A new issue to the same register in the cycle its previous write
        // retires must leave the bit set. The newer write is still
        // outstanding, so set takes priority over clear.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                busy_bit_reg <= 1'b0;
            end else if (set_bit) begin
                busy_bit_reg <= 1'b1;
            end else if (clr_bit) begin
                busy_bit_reg <= 1'b0;
            end
        end

        assign busy[gi] = busy_bit_reg;
    end

    // -------------------------------------------------------------------------
    // Write-cycle forwarding
    // -------------------------------------------------------------------------
`ifdef WB_FWD_EN
    // While WE3 is high, the register file still returns the old value for
    // A3. The in-flight write data is bypassed to any matching read port.
    // Because WE3 already excludes x0, a read of x0 never hits.
    assign fwd1_hit  = we3_int && (a3_reg == rs1);
    assign fwd2_hit  = we3_int && (a3_reg == rs2);
    assign fwd1_data = fwd1_hit ? wd3_reg : 32'd0;
    assign fwd2_data = fwd2_hit ? wd3_reg : 32'd0;
`else
    logic fwd_unused;

    // The read addresses are accepted but not used when forwarding is absent.
    assign fwd_unused = ^{rs1, rs2};

    assign fwd1_hit  = 1'b0;
    assign fwd2_hit  = 1'b0;
    assign fwd1_data = 32'd0;
    assign fwd2_data = 32'd0;
`endif

endmodule
